// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared constants for the sequential 8x8 multiplier: operand
//               and nibble widths, step count and the 3-bit FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

   localparam int C_OP_WIDTH    = 8;
   localparam int C_NIB_WIDTH   = 4;
   localparam int C_STEP_COUNT  = 4;
   localparam int C_STATE_WIDTH = 3;

   localparam logic [2:0] C_ST_IDLE  = 3'd0;
   localparam logic [2:0] C_ST_STEP0 = 3'd1;
   localparam logic [2:0] C_ST_STEP1 = 3'd2;
   localparam logic [2:0] C_ST_STEP2 = 3'd3;
   localparam logic [2:0] C_ST_STEP3 = 3'd4;
   localparam logic [2:0] C_ST_DONE  = 3'd5;

   // Step states are encoded contiguously starting at C_ST_STEP0.
   localparam logic [2:0] C_ST_LAST_STEP = C_ST_STEP0 + 3'(C_STEP_COUNT - 1);

   // True while the FSM is in one of the partial-product step states.
   function automatic logic is_step(input logic [2:0] state);
      return (state >= C_ST_STEP0) && (state <= C_ST_LAST_STEP);
   endfunction

endpackage
`default_nettype wire

// File: rtl/array_multiplier_4_bits.sv
`default_nettype none
// ============================================================================
// Module      : array_multiplier_4_bits
// Description : Combinational 4x4 unsigned array multiplier built as a chain
//               of shifted AND-gated partial-product rows.
// Revision    : 1.0 - initial release
// ============================================================================
module array_multiplier_4_bits (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] p
);

   logic [7:0] w_row [0:4];

   assign w_row[0] = 8'h00;

   // Each row adds a, gated by one bit of b, at that bit's weight.
   generate
      for (genvar i = 0; i < 4; i++) begin : g_row
         assign w_row[i+1] = w_row[i] + ({4'h0, (a & {4{b[i]}})} << i);
      end
   endgenerate

   assign p = w_row[4];

endmodule
`default_nettype wire

// File: rtl/mult8_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mult8_sequencer
// Description : 8x8 unsigned multiplier that time-shares one 4x4 multiplier
//               over four steps, accumulating shifted nibble products.
// Revision    : 1.0 - initial release
// ============================================================================
module mult8_sequencer
   import mult_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      abort,
   input  logic [C_OP_WIDTH-1:0]     a,
   input  logic [C_OP_WIDTH-1:0]     b,
   output logic                      busy,
   output logic                      done,
   output logic [2*C_OP_WIDTH-1:0]   p
);

   logic [C_STATE_WIDTH-1:0]  r_state;
   logic [C_STATE_WIDTH-1:0]  w_state_nxt;
   logic [C_OP_WIDTH-1:0]     r_a;
   logic [C_OP_WIDTH-1:0]     r_b;
   logic [2*C_OP_WIDTH-1:0]   r_acc;
   logic [2*C_OP_WIDTH-1:0]   r_p;
   logic [C_NIB_WIDTH-1:0]    w_mx;
   logic [C_NIB_WIDTH-1:0]    w_my;
   logic [2*C_NIB_WIDTH-1:0]  w_prod;
   logic [2*C_OP_WIDTH-1:0]   w_shifted;
   logic [2*C_OP_WIDTH-1:0]   w_sum;
   logic                      w_in_step;
   logic                      w_accept;

   assign w_in_step = is_step(r_state);
   assign w_accept  = start && ((r_state == C_ST_IDLE) || (r_state == C_ST_DONE));
   assign w_sum     = r_acc + w_shifted;

   // Nibble select for the shared multiplier, driven from latched operands only.
   always_comb begin
      w_mx = r_a[C_NIB_WIDTH-1:0];
      w_my = r_b[C_NIB_WIDTH-1:0];
      case (r_state)
         C_ST_STEP1: w_mx = r_a[C_OP_WIDTH-1:C_NIB_WIDTH];
         C_ST_STEP2: w_my = r_b[C_OP_WIDTH-1:C_NIB_WIDTH];
         C_ST_STEP3: begin
            w_mx = r_a[C_OP_WIDTH-1:C_NIB_WIDTH];
            w_my = r_b[C_OP_WIDTH-1:C_NIB_WIDTH];
         end
         default: ;
      endcase
   end

   array_multiplier_4_bits u_mul (
      .a (w_mx),
      .b (w_my),
      .p (w_prod)
   );

   // Weight the nibble product by the current step's bit position.
   always_comb begin
      w_shifted = {8'h00, w_prod};
      case (r_state)
         C_ST_STEP1,
         C_ST_STEP2: w_shifted = {4'h0, w_prod, 4'h0};
         C_ST_STEP3: w_shifted = {w_prod, 8'h00};
         default:    ;
      endcase
   end

   // Next-state logic: abort beats stepping, start wins over abort when idle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         C_ST_IDLE:  w_state_nxt = start ? C_ST_STEP0 : C_ST_IDLE;
         C_ST_STEP0: w_state_nxt = abort ? C_ST_IDLE  : C_ST_STEP1;
         C_ST_STEP1: w_state_nxt = abort ? C_ST_IDLE  : C_ST_STEP2;
         C_ST_STEP2: w_state_nxt = abort ? C_ST_IDLE  : C_ST_STEP3;
         C_ST_STEP3: w_state_nxt = abort ? C_ST_IDLE  : C_ST_DONE;
         C_ST_DONE:  w_state_nxt = start ? C_ST_STEP0 : C_ST_IDLE;
         default:    w_state_nxt = C_ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= C_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Operand capture on acceptance; held stable through all four steps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a <= '0;
         r_b <= '0;
      end else if (w_accept) begin
         r_a <= a;
         r_b <= b;
      end
   end

   // Accumulator: cleared on acceptance, adds one partial product per step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
      end else if (w_accept) begin
         r_acc <= '0;
      end else if (w_in_step && !abort) begin
         r_acc <= w_sum;
      end
   end

   // Product register: loaded with the final sum on the STEP3 -> DONE edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_p <= '0;
      end else if ((r_state == C_ST_STEP3) && !abort) begin
         r_p <= w_sum;
      end
   end

   assign busy = w_in_step;
   assign done = (r_state == C_ST_DONE);
   assign p    = r_p;

endmodule
`default_nettype wire
